// File: rtl/ascon_sequencer_if.sv
// User/datapath control bundle for the ASCON sequencer: start/block counts and data handshake in,
// datapath round controls and user strobes out; slave is the sequencer side.
interface ascon_sequencer_if #(parameter int BLK_W = 8);
   logic             start_i;
   logic [BLK_W-1:0] ad_blocks_i;
   logic [BLK_W-1:0] pt_blocks_i;
   logic             data_valid_i;
   logic             data_ready_o;
   logic             init_state_o;
   logic             perm_en_o;
   logic [3:0]       round_o;
   logic             xor_data_o;
   logic             xor_key_init_o;
   logic             xor_domsep_o;
   logic             xor_key_fin_o;
   logic             xor_key_tag_o;
   logic             cipher_valid_o;
   logic             end_o;
   logic             busy_o;

   modport master (
      output start_i, ad_blocks_i, pt_blocks_i, data_valid_i,
      input  data_ready_o, init_state_o, perm_en_o, round_o, xor_data_o, xor_key_init_o,
             xor_domsep_o, xor_key_fin_o, xor_key_tag_o, cipher_valid_o, end_o, busy_o
   );

   modport slave (
      input  start_i, ad_blocks_i, pt_blocks_i, data_valid_i,
      output data_ready_o, init_state_o, perm_en_o, round_o, xor_data_o, xor_key_init_o,
             xor_domsep_o, xor_key_fin_o, xor_key_tag_o, cipher_valid_o, end_o, busy_o
   );
endinterface

// File: rtl/ascon_sequencer.sv
// ASCON-128 encryption control FSM: Mealy strobes, registered round index; one accept cycle per block
// plus p^b/p^a rounds; stalls in WAIT_AD/WAIT_PT with data_ready_o high until data_valid_i arrives.
module ascon_sequencer #(
   parameter int PA_ROUNDS = 12,
   parameter int PB_ROUNDS = 6,
   parameter int BLK_W     = 8
) (
   input  logic              clock_i,
   input  logic              reset_i,
   ascon_sequencer_if.slave  bus
);

   localparam logic [3:0] RA_START = 4'(12 - PA_ROUNDS);
   localparam logic [3:0] RB_START = 4'(12 - PB_ROUNDS);
   localparam logic [3:0] R_LAST   = 4'd11;

   typedef enum logic [2:0] {
      IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FIN, END_S
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       round_q, round_d;
   logic [BLK_W-1:0] ad_q, ad_d;
   logic [BLK_W-1:0] pt_q, pt_d;

   logic init_state, perm_en, xor_data, xor_key_init, xor_domsep;
   logic xor_key_fin, xor_key_tag, cipher_valid, data_ready, end_flag;
   logic start_ok;

   function automatic logic [BLK_W-1:0] sat_dec(input logic [BLK_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   // keeps a start held across reset from producing an init pulse while reset is asserted
   assign start_ok = bus.start_i && !reset_i;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         round_q <= '0;
         ad_q    <= '0;
         pt_q    <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         ad_q    <= ad_d;
         pt_q    <= pt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      round_d      = round_q;
      ad_d         = ad_q;
      pt_d         = pt_q;
      init_state   = 1'b0;
      perm_en      = 1'b0;
      xor_data     = 1'b0;
      xor_key_init = 1'b0;
      xor_domsep   = 1'b0;
      xor_key_fin  = 1'b0;
      xor_key_tag  = 1'b0;
      cipher_valid = 1'b0;
      data_ready   = 1'b0;
      end_flag     = 1'b0;

      case (state_q)
         IDLE, END_S: begin
            end_flag = (state_q == END_S);
            if (start_ok) begin
               init_state = 1'b1;
               ad_d       = bus.ad_blocks_i;
               pt_d       = (bus.pt_blocks_i == '0) ? BLK_W'(1) : bus.pt_blocks_i;
               round_d    = RA_START;
               state_d    = INIT;
            end
         end
         INIT: begin
            perm_en = 1'b1;
            if (round_q == R_LAST) begin
               xor_key_init = 1'b1;
               round_d      = '0;
               if (ad_q == '0) begin
                  xor_domsep = 1'b1;
                  state_d    = WAIT_PT;
               end else begin
                  state_d    = WAIT_AD;
               end
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         WAIT_AD: begin
            data_ready = 1'b1;
            if (bus.data_valid_i) begin
               xor_data = 1'b1;
               ad_d     = sat_dec(ad_q);
               round_d  = RB_START;
               state_d  = AD;
            end
         end
         AD: begin
            perm_en = 1'b1;
            if (round_q == R_LAST) begin
               round_d = '0;
               if (ad_q == '0) begin
                  xor_domsep = 1'b1;
                  state_d    = WAIT_PT;
               end else begin
                  state_d    = WAIT_AD;
               end
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         WAIT_PT: begin
            data_ready = 1'b1;
            if (bus.data_valid_i) begin
               xor_data     = 1'b1;
               cipher_valid = 1'b1;
               pt_d         = sat_dec(pt_q);
               // the final block enters finalisation directly instead of a p^b pass
               if (pt_q <= BLK_W'(1)) begin
                  xor_key_fin = 1'b1;
                  round_d     = RA_START;
                  state_d     = FIN;
               end else begin
                  round_d     = RB_START;
                  state_d     = PT;
               end
            end
         end
         PT: begin
            perm_en = 1'b1;
            if (round_q == R_LAST) begin
               round_d = '0;
               state_d = WAIT_PT;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         FIN: begin
            perm_en = 1'b1;
            if (round_q == R_LAST) begin
               xor_key_tag = 1'b1;
               round_d     = '0;
               state_d     = END_S;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            round_d = '0;
         end
      endcase
   end

   assign bus.init_state_o   = init_state;
   assign bus.perm_en_o      = perm_en;
   assign bus.round_o        = round_q;
   assign bus.xor_data_o     = xor_data;
   assign bus.xor_key_init_o = xor_key_init;
   assign bus.xor_domsep_o   = xor_domsep;
   assign bus.xor_key_fin_o  = xor_key_fin;
   assign bus.xor_key_tag_o  = xor_key_tag;
   assign bus.cipher_valid_o = cipher_valid;
   assign bus.data_ready_o   = data_ready;
   assign bus.end_o          = end_flag;
   assign bus.busy_o         = (state_q != IDLE) && (state_q != END_S);

endmodule

// File: tb/tb_ascon_sequencer.sv
// Directed bench for ascon_sequencer: cycle-indexed runs checked against hand-derived event times.
module tb_ascon_sequencer;

   localparam int B_INIT = 10, B_PERM = 9, B_XD = 8, B_KI = 7, B_DS = 6, B_KF = 5;
   localparam int B_KT = 4, B_CV = 3, B_RDY = 2, B_END = 1, B_BUSY = 0;

   logic clock_i = 1'b0;
   logic reset_i;
   int   tests = 0;
   int   fails = 0;
   logic [10:0] ov;
   logic [3:0]  rv;

   always #5 clock_i = ~clock_i;

   ascon_sequencer_if #(.BLK_W(8)) bus ();

   ascon_sequencer #(.PA_ROUNDS(12), .PB_ROUNDS(6), .BLK_W(8)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock cycle: drive inputs, sample outputs at the falling edge, advance past the rising edge
   task automatic tick(input logic st, input logic dv);
      bus.start_i      = st;
      bus.data_valid_i = dv;
      @(negedge clock_i);
      ov = {bus.init_state_o, bus.perm_en_o, bus.xor_data_o, bus.xor_key_init_o,
            bus.xor_domsep_o, bus.xor_key_fin_o, bus.xor_key_tag_o, bus.cipher_valid_o,
            bus.data_ready_o, bus.end_o, bus.busy_o};
      rv = bus.round_o;
      @(posedge clock_i);
      #1;
   endtask

   task automatic do_reset(input string tag);
      reset_i          = 1'b1;
      bus.start_i      = 1'b0;
      bus.data_valid_i = 1'b0;
      @(negedge clock_i);
      check({tag, "_outs"}, 32'(ov_now()), 32'd0);
      check({tag, "_round"}, 32'(bus.round_o), 32'd0);
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
   endtask

   function automatic logic [10:0] ov_now();
      return {bus.init_state_o, bus.perm_en_o, bus.xor_data_o, bus.xor_key_init_o,
              bus.xor_domsep_o, bus.xor_key_fin_o, bus.xor_key_tag_o, bus.cipher_valid_o,
              bus.data_ready_o, bus.end_o, bus.busy_o};
   endfunction

   // ad=1, pt=3, data always valid: accepts at 13/20/27/34, tag at 46, end from 47
   function automatic logic [10:0] nom_exp(input int t);
      logic [10:0] e;
      e = '0;
      e[B_INIT] = (t == 0);
      e[B_PERM] = (t >= 1 && t <= 12) || (t >= 14 && t <= 19) || (t >= 21 && t <= 26) ||
                  (t >= 28 && t <= 33) || (t >= 35 && t <= 46);
      e[B_XD]   = (t == 13) || (t == 20) || (t == 27) || (t == 34);
      e[B_KI]   = (t == 12);
      e[B_DS]   = (t == 19);
      e[B_KF]   = (t == 34);
      e[B_KT]   = (t == 46);
      e[B_CV]   = (t == 20) || (t == 27) || (t == 34);
      e[B_RDY]  = e[B_XD];
      e[B_END]  = (t >= 47);
      e[B_BUSY] = (t >= 1 && t <= 46);
      return e;
   endfunction

   function automatic logic [3:0] nom_round(input int t);
      if (t >= 1 && t <= 12)  return 4'(t - 1);
      if (t >= 14 && t <= 19) return 4'(t - 8);
      if (t >= 21 && t <= 26) return 4'(t - 15);
      if (t >= 28 && t <= 33) return 4'(t - 22);
      if (t >= 35 && t <= 46) return 4'(t - 35);
      return 4'd0;
   endfunction

   initial begin
      reset_i          = 1'b1;
      bus.start_i      = 1'b0;
      bus.data_valid_i = 1'b0;
      bus.ad_blocks_i  = 8'd0;
      bus.pt_blocks_i  = 8'd0;
      @(posedge clock_i);
      #1;
      do_reset("por");

      // reset mid-INIT
      bus.ad_blocks_i = 8'd1;
      bus.pt_blocks_i = 8'd1;
      for (int t = 0; t < 6; t++) tick(t == 0, 1'b0);
      check("rst_pre_round", 32'(rv), 32'd4);
      reset_i = 1'b1;
      @(negedge clock_i);
      check("rst_mid_outs", 32'(ov_now()), 32'd0);
      check("rst_mid_round", 32'(bus.round_o), 32'd0);
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
      for (int t = 0; t < 15; t++) begin
         tick(1'b0, 1'b1);
         check($sformatf("rst_after_outs@%0d", t), 32'(ov), 32'd0);
      end

      // nominal run
      do_reset("pre_nom");
      bus.ad_blocks_i = 8'd1;
      bus.pt_blocks_i = 8'd3;
      for (int t = 0; t < 50; t++) begin
         tick(t == 0, 1'b1);
         check($sformatf("nom_outs@T%0d", t), 32'(ov), 32'(nom_exp(t)));
         check($sformatf("nom_round@T%0d", t), 32'(rv), 32'(nom_round(t)));
      end

      // no AD; pt=0 must behave as pt=1
      for (int k = 0; k < 2; k++) begin
         do_reset("pre_noad");
         bus.ad_blocks_i = 8'd0;
         bus.pt_blocks_i = 8'(1 - k);
         for (int t = 0; t < 28; t++) begin
            tick(t == 0, 1'b1);
            if (t == 11) check($sformatf("noad%0d_ds_T11", k), 32'(ov[B_DS]), 32'd0);
            if (t == 12) begin
               check($sformatf("noad%0d_ki_T12", k), 32'(ov[B_KI]), 32'd1);
               check($sformatf("noad%0d_ds_T12", k), 32'(ov[B_DS]), 32'd1);
            end
            if (t == 13) begin
               check($sformatf("noad%0d_xd_T13", k), 32'(ov[B_XD]), 32'd1);
               check($sformatf("noad%0d_kf_T13", k), 32'(ov[B_KF]), 32'd1);
               check($sformatf("noad%0d_cv_T13", k), 32'(ov[B_CV]), 32'd1);
            end
            if (t == 25) begin
               check($sformatf("noad%0d_kt_T25", k), 32'(ov[B_KT]), 32'd1);
               check($sformatf("noad%0d_end_T25", k), 32'(ov[B_END]), 32'd0);
            end
            if (t == 26) check($sformatf("noad%0d_end_T26", k), 32'(ov[B_END]), 32'd1);
         end
      end

      // stalled data in WAIT_PT
      do_reset("pre_stall");
      bus.ad_blocks_i = 8'd1;
      bus.pt_blocks_i = 8'd2;
      for (int t = 0; t < 47; t++) begin
         tick(t == 0, !(t >= 20 && t <= 24));
         if (t >= 20 && t <= 24) begin
            check($sformatf("stall_rdy@T%0d", t), 32'(ov[B_RDY]), 32'd1);
            check($sformatf("stall_perm@T%0d", t), 32'(ov[B_PERM]), 32'd0);
            check($sformatf("stall_cv@T%0d", t), 32'(ov[B_CV]), 32'd0);
         end
         if (t == 25) begin
            check("stall_cv_T25", 32'(ov[B_CV]), 32'd1);
            check("stall_kf_T25", 32'(ov[B_KF]), 32'd0);
         end
         if (t == 32) check("stall_kf_T32", 32'(ov[B_KF]), 32'd1);
         if (t == 44) begin
            check("stall_kt_T44", 32'(ov[B_KT]), 32'd1);
            check("stall_end_T44", 32'(ov[B_END]), 32'd0);
         end
         if (t == 45) check("stall_end_T45", 32'(ov[B_END]), 32'd1);
      end

      // start ignored while busy, accepted in END
      do_reset("pre_restart");
      bus.ad_blocks_i = 8'd1;
      bus.pt_blocks_i = 8'd1;
      for (int t = 0; t < 38; t++) begin
         tick(t == 0 || t == 16 || t == 35, 1'b1);
         if (t == 16) begin
            check("rs_init_T16", 32'(ov[B_INIT]), 32'd0);
            check("rs_round_T16", 32'(rv), 32'd8);
         end
         if (t == 17) check("rs_round_T17", 32'(rv), 32'd9);
         if (t == 20) check("rs_kf_T20", 32'(ov[B_KF]), 32'd1);
         if (t == 33) check("rs_end_T33", 32'(ov[B_END]), 32'd1);
         if (t == 35) begin
            check("rs_end_T35", 32'(ov[B_END]), 32'd1);
            check("rs_init_T35", 32'(ov[B_INIT]), 32'd1);
         end
         if (t == 36) begin
            check("rs_end_T36", 32'(ov[B_END]), 32'd0);
            check("rs_busy_T36", 32'(ov[B_BUSY]), 32'd1);
            check("rs_perm_T36", 32'(ov[B_PERM]), 32'd1);
            check("rs_round_T36", 32'(rv), 32'd0);
         end
         if (t == 37) check("rs_round_T37", 32'(rv), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ascon_sequencer.md
# ascon_sequencer

Control FSM that sequences the ASCON-128 permutation datapath through one authenticated-encryption run: initialisation, associated-data absorption, plaintext encryption and finalisation. It owns the round counter and the block counters. Each cycle it drives the datapath's round index, permutation enable and state-XOR controls. It also generates the user-side handshake (`data_ready_o`, `cipher_valid_o`, `end_o`). It sits inside the ASCON top level, between the external data/start interface and the permutation/state-register datapath.

## Interface
- `PA_ROUNDS`, 12: rounds of p^a (init and final); round index runs 12-PA_ROUNDS..11.
- `PB_ROUNDS`, 6: rounds of p^b (AD and plaintext); round index runs 12-PB_ROUNDS..11.
- `BLK_W`, 8: width of block counters.

- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: starts a run; sampled only in IDLE or END.
- `ad_blocks_i` in BLK_W: number of padded AD blocks; 0 means no AD. Latched on accepted start.
- `pt_blocks_i` in BLK_W: number of padded plaintext blocks, last one included; 0 is treated as 1. Latched on accepted start.
- `data_valid_i` in 1: data block present on the datapath data input.
- `data_ready_o` out 1: sequencer waits for a block.
- `init_state_o` out 1: load IV‖K‖N into the state register.
- `perm_en_o` out 1: apply one permutation round this cycle.
- `round_o` out 4: round-constant index for the round.
- `xor_data_o` out 1: XOR the data block into x0 before the round.
- `xor_key_init_o` out 1: XOR 0‖K into the state after the round.
- `xor_domsep_o` out 1: XOR 1 into the LSB of x4 after the round.
- `xor_key_fin_o` out 1: XOR K into x1,x2 before the round.
- `xor_key_tag_o` out 1: XOR K into x3,x4 after the round; the tag is then valid.
- `cipher_valid_o` out 1: x0^data is a valid cipher block this cycle.
- `end_o` out 1: run complete; tag valid.
- `busy_o` out 1: high in every state except IDLE and END.

## Operation
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FIN, END.
- **IDLE/END.** On `start_i`:
  - pulse `init_state_o`.
  - latch both block counts into down-counters.
  - set round counter to 12-PA_ROUNDS.
  - go to INIT.
  - END otherwise holds `end_o`=1.
- **INIT.**
  - `perm_en_o`=1 every cycle; round increments.
  - At round 11: `xor_key_init_o`=1. If ad count is 0, `xor_domsep_o`=1 in the same cycle, then go to WAIT_PT; otherwise go to WAIT_AD.
- **WAIT_AD.**
  - `data_ready_o`=1.
  - On `data_valid_i`: `xor_data_o`=1, ad count decrements, round set to 12-PB_ROUNDS, go to AD.
  - No round is executed in this cycle.
- **AD.**
  - PB_ROUNDS cycles of `perm_en_o`.
  - At round 11: if the remaining ad count is 0, `xor_domsep_o`=1 and go to WAIT_PT; otherwise go to WAIT_AD.
- **WAIT_PT.**
  - `data_ready_o`=1.
  - On `data_valid_i`: `xor_data_o`=1, `cipher_valid_o`=1, pt count decrements.
  - If more blocks remain: round set to 12-PB_ROUNDS, go to PT.
  - If this was the last block: `xor_key_fin_o`=1, round set to 12-PA_ROUNDS, go to FIN.
- **PT.**
  - PB_ROUNDS cycles of `perm_en_o`, then WAIT_PT.
- **FIN.**
  - PA_ROUNDS cycles of `perm_en_o`.
  - At round 11: `xor_key_tag_o`=1, go to END.
- **Output decoding.** All pulse outputs are combinational from state and inputs (Mealy). `round_o` is registered. `round_o` is 0 outside permutation states.
- **Ignored inputs.**
  - `data_valid_i` outside WAIT_AD/WAIT_PT: ignored.
  - `start_i` while busy: ignored.
- **Boundary conditions.**
  - Down-counters saturate at 0.
  - pt count latched as 0 → stored as 1.
  - Block counts are unsigned.

## Timing
- Reset: state IDLE, all counters 0. Every output is 0, including `round_o`, `busy_o` and `end_o`.
- Reset asserted mid-run: immediate return to IDLE. No pulse is generated on the clock edge after release.
- Start accepted in cycle T0; INIT rounds occupy T1..T(PA_ROUNDS).
- First `data_ready_o` appears in cycle T(PA_ROUNDS+1) = T13 with defaults.
- Each accepted block costs 1 accept cycle plus PB_ROUNDS round cycles.
- Final block costs 1 accept cycle plus PA_ROUNDS round cycles; `end_o` rises one cycle after `xor_key_tag_o`.
- With `data_valid_i` held high, the total from start to `end_o` is 1 + PA + (ad+pt)·(1+PB) − PB + PA cycles after T0.
- `data_ready_o` and the accept pulses are in the same cycle. Back-to-back blocks: no bubble besides the rounds.
- `start_i` in END: `end_o` drops in the next cycle together with the INIT entry.

## Test plan
- **Reset values.** Assert `reset_i` mid-INIT at round 5 → all outputs 0 in the same cycle; no `perm_en_o` until a new `start_i`.
- **Nominal run.** ad=1, pt=3, `data_valid_i` held high, start at T0. Required response:
  - `init_state_o`@T0.
  - `xor_key_init_o`@T12.
  - accept A1@T13.
  - `xor_domsep_o`@T19.
  - `cipher_valid_o`@T20, T27, T34.
  - `xor_key_fin_o`@T34.
  - `xor_key_tag_o`@T46.
  - `end_o`=1 from T47.
- **Round indices.** Same run → `round_o` runs 0..11 in INIT/FIN and 6..11 in AD/PT.
- **No AD.** ad=0, pt=1 → `xor_key_init_o` and `xor_domsep_o` both @T12; data accept and `xor_key_fin_o` @T13; `end_o`@T26.
- **Stalled data.** ad=1, pt=2, `data_valid_i` low for 5 cycles in WAIT_PT → `data_ready_o` stays high; no `perm_en_o`; the run resumes with the same counts.
- **Restart and ignore.** `start_i` pulsed during AD → ignored. `start_i` in END → `end_o` falls and `init_state_o` pulses.
